// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
//   SPI target endpoint. The SPI pins are oversampled on clk. Each frame is one
//   command bit (1 = read, 0 = write) followed by DATA_W data bits, LSB first.
//   A write frame delivers a byte to the core. A read frame shifts out a byte
//   that the core loaded earlier into a shadow register.
//
// Ports
//   clk        in   1       system clock
//   reset_n    in   1       asynchronous active-low reset
//   sclk       in   1       SPI clock from the master, idles high
//   mosi       in   1       serial data from the master
//   cs         in   1       chip select, active low
//   tx_data    in   DATA_W  byte returned on the next read frame
//   tx_load    in   1       strobe: capture tx_data into the shadow register
//   miso       out  1       serial data to the master
//   rx_data    out  DATA_W  last byte received by a write frame
//   rx_valid   out  1       pulse: rx_data updated
//   rd_start   out  1       pulse: read command decoded, shifting begins
//   busy       out  1       frame in progress
//   frame_err  out  1       pulse: cs rose before the frame completed
// -----------------------------------------------------------------------------
module spi_slave_if #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rd_start,
    output logic              busy,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Pin synchronisers plus one delay flop for edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic                   sclk_dly_r;
    logic                   cs_dly_r;

    logic sclk_now_s;
    logic mosi_now_s;
    logic cs_now_s;
    logic sclk_fall_s;
    logic cs_rise_s;
    logic cs_fall_s;

    // Registered state and its next-state values
    state_t            state_r,     state_s;
    logic [CNT_W-1:0]  cnt_r,       cnt_s;
    logic [DATA_W-1:0] rx_shift_r,  rx_shift_s;
    logic [DATA_W-1:0] tx_shift_r,  tx_shift_s;
    logic [DATA_W-1:0] shadow_r,    shadow_s;
    logic [DATA_W-1:0] rx_data_r,   rx_data_s;
    logic              miso_r,      miso_s;
    logic              rx_valid_r,  rx_valid_s;
    logic              rd_start_r,  rd_start_s;
    logic              busy_r,      busy_s;
    logic              frame_err_r, frame_err_s;

    logic [DATA_W-1:0] load_val_s;
    logic [DATA_W-1:0] wr_byte_s;

    // Synchroniser chains; preset to 1 so reset looks like an idle bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_r <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b1}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_dly_r  <= 1'b1;
            cs_dly_r    <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
            sclk_dly_r  <= sclk_sync_r[SYNC_STAGES-1];
            cs_dly_r    <= cs_sync_r[SYNC_STAGES-1];
        end
    end

    // Edge detection on the synchronised pins
    always_comb begin
        sclk_now_s  = sclk_sync_r[SYNC_STAGES-1];
        mosi_now_s  = mosi_sync_r[SYNC_STAGES-1];
        cs_now_s    = cs_sync_r[SYNC_STAGES-1];
        sclk_fall_s = sclk_dly_r & ~sclk_now_s;
        cs_rise_s   = ~cs_dly_r & cs_now_s;
        cs_fall_s   = cs_dly_r & ~cs_now_s;
    end

    // Next-state and next-output logic for the frame FSM
    always_comb begin
        // A load coinciding with read decode must feed that very frame
        load_val_s = tx_load ? tx_data : shadow_r;
        wr_byte_s  = rx_shift_r;
        wr_byte_s[cnt_r] = mosi_now_s;

        state_s     = state_r;
        cnt_s       = cnt_r;
        rx_shift_s  = rx_shift_r;
        tx_shift_s  = tx_shift_r;
        shadow_s    = load_val_s;
        rx_data_s   = rx_data_r;
        miso_s      = miso_r;
        rx_valid_s  = 1'b0;
        rd_start_s  = 1'b0;
        busy_s      = busy_r;
        frame_err_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_s    = ST_CMD;
                    busy_s     = 1'b1;
                    cnt_s      = {CNT_W{1'b0}};
                    rx_shift_s = {DATA_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (cs_rise_s) begin
                    state_s     = ST_IDLE;
                    busy_s      = 1'b0;
                    frame_err_s = 1'b1;
                end else if (sclk_fall_s) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (mosi_now_s) begin
                        state_s    = ST_READ;
                        tx_shift_s = load_val_s;
                        miso_s     = load_val_s[0];
                        rd_start_s = 1'b1;
                    end else begin
                        state_s = ST_WRITE;
                    end
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_WRITE: begin
                // The final bit wins over a simultaneous cs rise
                if (sclk_fall_s && (cnt_r == LAST_BIT)) begin
                    rx_shift_s = wr_byte_s;
                    rx_data_s  = wr_byte_s;
                    rx_valid_s = 1'b1;
                    state_s    = cs_rise_s ? ST_IDLE : ST_DONE;
                    busy_s     = ~cs_rise_s;
                end else if (cs_rise_s) begin
                    state_s     = ST_IDLE;
                    busy_s      = 1'b0;
                    frame_err_s = 1'b1;
                end else if (sclk_fall_s) begin
                    rx_shift_s = wr_byte_s;
                    cnt_s      = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_READ: begin
                // miso already holds bit 0; each fall presents the next bit,
                // and the last bit stays on miso after the final fall
                if (sclk_fall_s && (cnt_r == LAST_BIT)) begin
                    state_s = cs_rise_s ? ST_IDLE : ST_DONE;
                    busy_s  = ~cs_rise_s;
                end else if (cs_rise_s) begin
                    state_s     = ST_IDLE;
                    busy_s      = 1'b0;
                    frame_err_s = 1'b1;
                end else if (sclk_fall_s) begin
                    miso_s     = tx_shift_r[1];
                    tx_shift_s = {1'b0, tx_shift_r[DATA_W-1:1]};
                    cnt_s      = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DONE: begin
                if (cs_rise_s) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rx_shift_r  <= {DATA_W{1'b0}};
            tx_shift_r  <= {DATA_W{1'b0}};
            shadow_r    <= {DATA_W{1'b0}};
            rx_data_r   <= {DATA_W{1'b0}};
            miso_r      <= 1'b0;
            rx_valid_r  <= 1'b0;
            rd_start_r  <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            rx_shift_r  <= rx_shift_s;
            tx_shift_r  <= tx_shift_s;
            shadow_r    <= shadow_s;
            rx_data_r   <= rx_data_s;
            miso_r      <= miso_s;
            rx_valid_r  <= rx_valid_s;
            rd_start_r  <= rd_start_s;
            busy_r      <= busy_s;
            frame_err_r <= frame_err_s;
        end
    end

    assign miso      = miso_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign rd_start  = rd_start_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave_if.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_if
//   Directed bench for spi_slave_if. An SPI master is modelled with tasks;
//   a small model tracks what rx_data, miso and the shadow byte must be, and a
//   per-cycle compare process checks the DUT against it whenever no frame is
//   in progress, and counts the single-cycle pulses.
// -----------------------------------------------------------------------------
module tb_spi_slave_if;

    localparam int H = 9;   // sclk half-period in clk cycles

    logic       clk;
    logic       reset_n;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_start;
    logic       busy;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int n_rxv    = 0;
    int n_rds    = 0;
    int n_ferr   = 0;

    // Model state
    logic [7:0] model_rx_data = 8'h00;
    logic [7:0] model_shadow  = 8'h00;
    logic       model_miso    = 1'b0;

    spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .miso      (miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rd_start  (rd_start),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model, plus pulse accounting
    always @(negedge clk) begin
        if (rx_valid)  n_rxv++;
        if (rd_start)  n_rds++;
        if (frame_err) n_ferr++;
        if (rx_valid || rd_start || frame_err)
            chk("pulse_overlap", 32'(rx_valid) + 32'(rd_start) + 32'(frame_err), 32'd1);
        if (!busy) begin
            chk("idle_rx_data", 32'(rx_data), 32'(model_rx_data));
            chk("idle_miso", 32'(miso), 32'(model_miso));
        end
    end

    // One bit: present mosi, hold sclk high, fall, then sample miso before the rise
    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        wait_clk(H);
        sclk = 1'b0;
        wait_clk(H);
        m = miso;
        sclk = 1'b1;
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        model_shadow = v;
    endtask

    // Full or truncated frame; optional tx_load before data bit load_at
    task automatic frame(input logic cmd, input logic [7:0] data, input int nbits,
                         input int idle, input int load_at, input logic [7:0] load_val,
                         output logic [7:0] got);
        logic [7:0] exp_b;
        logic [7:0] g;
        logic       m;
        exp_b = model_shadow;
        g     = 8'h00;
        cs = 1'b0;
        wait_clk(5);
        chk("busy_in_frame", 32'(busy), 32'd1);
        send_bit(cmd, m);
        g[0] = m;
        for (int i = 0; i < nbits; i++) begin
            if (i == load_at) load_tx(load_val);
            send_bit(data[i], m);
            if (i < 7) g[i+1] = m;
        end
        if (nbits == 8) begin
            if (cmd) begin
                model_miso = exp_b[7];
                chk("read_vs_model", 32'(g), 32'(exp_b));
            end else begin
                model_rx_data = data;
            end
        end
        wait_clk(H);
        cs = 1'b1;
        wait_clk(idle);
        got = g;
    endtask

    initial begin
        logic [7:0] got;
        logic       m;
        int v0, r0, e0;

        reset_n = 1'b0;
        sclk    = 1'b1;
        mosi    = 1'b0;
        cs      = 1'b1;
        tx_data = 8'h00;
        tx_load = 1'b0;
        wait_clk(3);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_pulses", {29'd0, rx_valid, rd_start, frame_err}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        wait_clk(3);

        // 1. write 0xA5
        v0 = n_rxv; r0 = n_rds; e0 = n_ferr;
        frame(1'b0, 8'hA5, 8, 8, -1, 8'h00, got);
        chk("t1_rx_data", 32'(rx_data), 32'hA5);
        chk("t1_rx_valid_cnt", 32'(n_rxv - v0), 32'd1);
        chk("t1_no_err", 32'(n_ferr - e0), 32'd0);
        chk("t1_busy_low", 32'(busy), 32'd0);

        // 2. read 0x3C
        load_tx(8'h3C);
        v0 = n_rxv; r0 = n_rds;
        frame(1'b1, 8'h00, 8, 8, -1, 8'h00, got);
        chk("t2_read_byte", 32'(got), 32'h3C);
        chk("t2_rd_start_cnt", 32'(n_rds - r0), 32'd1);
        chk("t2_no_rx_valid", 32'(n_rxv - v0), 32'd0);

        // 3. abort after 4 write data bits
        v0 = n_rxv; e0 = n_ferr;
        frame(1'b0, 8'h0F, 4, 8, -1, 8'h00, got);
        chk("t3_frame_err_cnt", 32'(n_ferr - e0), 32'd1);
        chk("t3_no_rx_valid", 32'(n_rxv - v0), 32'd0);
        chk("t3_rx_data_kept", 32'(rx_data), 32'hA5);
        chk("t3_busy_low", 32'(busy), 32'd0);

        // 4. back-to-back writes with one idle clk
        v0 = n_rxv; e0 = n_ferr;
        frame(1'b0, 8'h01, 8, 1, -1, 8'h00, got);
        frame(1'b0, 8'hFF, 8, 8, -1, 8'h00, got);
        chk("t4_rx_valid_cnt", 32'(n_rxv - v0), 32'd2);
        chk("t4_rx_data", 32'(rx_data), 32'hFF);
        chk("t4_no_err", 32'(n_ferr - e0), 32'd0);

        // 5. mid-read tx_load of 0x55
        r0 = n_rds;
        frame(1'b1, 8'h00, 8, 8, 3, 8'h55, got);
        chk("t5_cur_read", 32'(got), 32'h3C);
        frame(1'b1, 8'h00, 8, 8, -1, 8'h00, got);
        chk("t5_next_read", 32'(got), 32'h55);
        chk("t5_rd_start_cnt", 32'(n_rds - r0), 32'd2);

        // 6. reset mid-write, then write 0x7E
        v0 = n_rxv; e0 = n_ferr;
        cs = 1'b0;
        wait_clk(5);
        send_bit(1'b0, m);
        send_bit(1'b1, m);
        send_bit(1'b0, m);
        send_bit(1'b1, m);
        reset_n = 1'b0;
        cs = 1'b1;
        model_rx_data = 8'h00;
        model_miso    = 1'b0;
        model_shadow  = 8'h00;
        wait_clk(3);
        chk("t6_rst_rx_data", 32'(rx_data), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_miso", 32'(miso), 32'd0);
        chk("t6_rst_pulses", {29'd0, rx_valid, rd_start, frame_err}, 32'd0);
        reset_n = 1'b1;
        wait_clk(3);
        frame(1'b0, 8'h7E, 8, 8, -1, 8'h00, got);
        chk("t6_rx_data", 32'(rx_data), 32'h7E);
        chk("t6_rx_valid_cnt", 32'(n_rxv - v0), 32'd1);
        chk("t6_no_err", 32'(n_ferr - e0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
